// File: rtl/gshare_predictor_pkg.sv
// +----------------------------------------------------------------------------+
// | gshare_predictor_pkg                                                       |
// | Default widths and counter-encoding helper for the direction predictor.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package gshare_predictor_pkg;

  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_CTR_BITS   = 2;
  localparam int DEF_HIST_BITS  = 6;
  localparam int MAX_CTR_BITS   = 4;

  typedef enum logic {
    DIR_NOT_TAKEN = 1'b0,
    DIR_TAKEN     = 1'b1
  } dir_e;

  // Weakly-not-taken: the value just below the taken threshold.
  function automatic logic [MAX_CTR_BITS-1:0] ctr_weak_nt(input int bits);
    ctr_weak_nt = MAX_CTR_BITS'((1 << (bits - 1)) - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gshare_predictor_if.sv
// +----------------------------------------------------------------------------+
// | gshare_predictor_if                                                        |
// | Fetch-side prediction, RoB-side training/repair and statistics signals.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface gshare_predictor_if #(
  parameter int HIST_BITS = 6
);

  logic                 if_valid;
  logic [31:0]          if_pc;
  logic                 pred_taken;
  logic [HIST_BITS-1:0] pred_ghr;
  logic                 rob_valid;
  logic [31:0]          rob_pc;
  logic [HIST_BITS-1:0] rob_ghr;
  logic                 rob_taken;
  logic                 rob_mispredict;
  logic [31:0]          stat_commits;
  logic [31:0]          stat_mispredicts;

  modport master (
    output if_valid, if_pc, rob_valid, rob_pc, rob_ghr, rob_taken, rob_mispredict,
    input  pred_taken, pred_ghr, stat_commits, stat_mispredicts
  );

  modport slave (
    input  if_valid, if_pc, rob_valid, rob_pc, rob_ghr, rob_taken, rob_mispredict,
    output pred_taken, pred_ghr, stat_commits, stat_mispredicts
  );

endinterface

`default_nettype wire

// File: rtl/gshare_predictor_sat_counter_table.sv
// +----------------------------------------------------------------------------+
// | sat_counter_table                                                          |
// | Saturating-counter array: async read, one sync saturating inc/dec write.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_counter_table
  import gshare_predictor_pkg::*;
#(
  parameter int DEPTH_BITS = DEF_INDEX_BITS,
  parameter int WIDTH      = DEF_CTR_BITS
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_n_i,
  input  wire logic [DEPTH_BITS-1:0] rd_idx_i,
  output logic      [WIDTH-1:0]      rd_ctr_o,
  input  wire logic                  wr_en_i,
  input  wire logic [DEPTH_BITS-1:0] wr_idx_i,
  input  wire logic                  wr_inc_i
);

  localparam int               c_depth   = 1 << DEPTH_BITS;
  localparam logic [WIDTH-1:0] c_weak_nt = WIDTH'(ctr_weak_nt(WIDTH));
  localparam logic [WIDTH-1:0] c_ctr_max = '1;

  logic [WIDTH-1:0] ctr_q [c_depth];
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign wr_old   = ctr_q[wr_idx_i];

  always_comb begin
    wr_ctr_d = wr_old;
    if (wr_inc_i && (wr_old != c_ctr_max)) begin
      wr_ctr_d = wr_old + WIDTH'(1);
    end else if (!wr_inc_i && (wr_old != '0)) begin
      wr_ctr_d = wr_old - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < c_depth; i++) begin
        ctr_q[i] <= c_weak_nt;
      end
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= wr_ctr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gshare_predictor.sv
// +----------------------------------------------------------------------------+
// | gshare_predictor                                                           |
// | PC^GHR-indexed direction predictor with speculative history and repair.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int CTR_BITS   = DEF_CTR_BITS,
  parameter int HIST_BITS  = DEF_HIST_BITS,
  parameter int USE_GHR    = 1
) (
  input wire logic           clk_in,
  input wire logic           rst_n_in,
  input wire logic           rdy_in,
  gshare_predictor_if.slave  bp_if
);

  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [HIST_BITS-1:0]  spec_ghr, repair_ghr;
  logic [31:0]           commits_q, mispredicts_q;
  logic [INDEX_BITS-1:0] fetch_hash, rob_hash;
  logic [INDEX_BITS-1:0] fetch_idx, rob_idx;
  logic [CTR_BITS-1:0]   fetch_ctr;
  logic                  pred_taken;
  logic                  train_en;
  logic                  repair_en;
  logic                  unused_bits;

  generate
    if (USE_GHR != 0) begin : g_gshare
      assign fetch_hash = INDEX_BITS'(ghr_q);
      assign rob_hash   = INDEX_BITS'(bp_if.rob_ghr);
    end else begin : g_bimodal
      assign fetch_hash = '0;
      assign rob_hash   = '0;
    end
  endgenerate

  assign fetch_idx = bp_if.if_pc[INDEX_BITS+1:2]  ^ fetch_hash;
  assign rob_idx   = bp_if.rob_pc[INDEX_BITS+1:2] ^ rob_hash;

  sat_counter_table #(
    .DEPTH_BITS (INDEX_BITS),
    .WIDTH      (CTR_BITS)
  ) u_pht (
    .clk_i    (clk_in),
    .rst_n_i  (rst_n_in),
    .rd_idx_i (fetch_idx),
    .rd_ctr_o (fetch_ctr),
    .wr_en_i  (train_en),
    .wr_idx_i (rob_idx),
    .wr_inc_i (bp_if.rob_taken)
  );

  assign pred_taken = fetch_ctr[CTR_BITS-1];

  generate
    if (HIST_BITS > 1) begin : g_hist_wide
      assign spec_ghr   = {ghr_q[HIST_BITS-2:0], pred_taken};
      assign repair_ghr = {bp_if.rob_ghr[HIST_BITS-2:0], bp_if.rob_taken};
    end else begin : g_hist_one
      assign spec_ghr   = pred_taken;
      assign repair_ghr = bp_if.rob_taken;
    end
  endgenerate

  assign train_en  = rdy_in && bp_if.rob_valid;
  assign repair_en = train_en && bp_if.rob_mispredict;

  // Repair wins over the same-cycle speculative shift: the fetched path is wrong.
  always_comb begin
    ghr_d = ghr_q;
    if (repair_en) begin
      ghr_d = repair_ghr;
    end else if (rdy_in && bp_if.if_valid) begin
      ghr_d = spec_ghr;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ghr_q         <= '0;
      commits_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (train_en) begin
        commits_q <= commits_q + 32'd1;
      end
      if (repair_en) begin
        mispredicts_q <= mispredicts_q + 32'd1;
      end
    end
  end

  assign bp_if.pred_taken       = pred_taken;
  assign bp_if.pred_ghr         = ghr_q;
  assign bp_if.stat_commits     = commits_q;
  assign bp_if.stat_mispredicts = mispredicts_q;

  assign unused_bits = ^{bp_if.if_pc[31:INDEX_BITS+2], bp_if.if_pc[1:0],
                         bp_if.rob_pc[31:INDEX_BITS+2], bp_if.rob_pc[1:0],
                         bp_if.rob_ghr};

endmodule

`default_nettype wire

// File: tb/tb_gshare_predictor.sv
// +----------------------------------------------------------------------------+
// | tb_gshare_predictor                                                        |
// | Drives a gshare and a bimodal instance in lockstep against a table model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_gshare_predictor;

  localparam int IB = 6;
  localparam int CB = 2;
  localparam int HB = 6;
  localparam int N  = 1 << IB;
  localparam int CMAX = (1 << CB) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rdy = 1'b1;

  always #5 clk = ~clk;

  gshare_predictor_if #(.HIST_BITS(HB)) if_gs ();
  gshare_predictor_if #(.HIST_BITS(HB)) if_bm ();

  gshare_predictor #(.INDEX_BITS(IB), .CTR_BITS(CB), .HIST_BITS(HB), .USE_GHR(1)) dut_gs (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .bp_if    (if_gs)
  );

  gshare_predictor #(.INDEX_BITS(IB), .CTR_BITS(CB), .HIST_BITS(HB), .USE_GHR(0)) dut_bm (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .bp_if    (if_bm)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: [0] = gshare instance, [1] = bimodal instance.
  int          pht [2][N];
  int          ghr [2];
  logic [31:0] commits;
  logic [31:0] misp;

  logic        cur_ifv, cur_robv, cur_taken, cur_misp;
  logic [31:0] cur_ifpc, cur_robpc;
  int          cur_robghr;

  function automatic int idx(input int u, input logic [31:0] pc, input int h);
    int base;
    base = int'((pc >> 2) % N);
    return (u == 0) ? (base ^ h) : base;
  endfunction

  function automatic int model_pred(input int u);
    return (pht[u][idx(u, cur_ifpc, ghr[u])] >= (1 << (CB - 1))) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < N; i++) pht[u][i] = (1 << (CB - 1)) - 1;
      ghr[u] = 0;
    end
    commits = '0;
    misp    = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("gs.pred_taken",  32'(if_gs.pred_taken), 32'(model_pred(0)));
    check("gs.pred_ghr",    32'(if_gs.pred_ghr),   32'(ghr[0]));
    check("gs.commits",     if_gs.stat_commits,     commits);
    check("gs.mispredicts", if_gs.stat_mispredicts, misp);
    check("bm.pred_taken",  32'(if_bm.pred_taken), 32'(model_pred(1)));
    check("bm.pred_ghr",    32'(if_bm.pred_ghr),   32'(ghr[1]));
    check("bm.commits",     if_bm.stat_commits,     commits);
    check("bm.mispredicts", if_bm.stat_mispredicts, misp);
  endtask

  task automatic set_inputs(input logic ifv, input logic [31:0] ifpc, input logic robv,
                            input logic [31:0] robpc, input int robghr, input logic tk,
                            input logic mp, input logic r);
    cur_ifv = ifv; cur_ifpc = ifpc; cur_robv = robv; cur_robpc = robpc;
    cur_robghr = robghr; cur_taken = tk; cur_misp = mp; rdy = r;
    if_gs.if_valid = ifv; if_gs.if_pc = ifpc; if_gs.rob_valid = robv; if_gs.rob_pc = robpc;
    if_gs.rob_ghr = HB'(robghr); if_gs.rob_taken = tk; if_gs.rob_mispredict = mp;
    if_bm.if_valid = ifv; if_bm.if_pc = ifpc; if_bm.rob_valid = robv; if_bm.rob_pc = robpc;
    if_bm.rob_ghr = HB'(robghr); if_bm.rob_taken = tk; if_bm.rob_mispredict = mp;
  endtask

  task automatic drive(input logic ifv, input logic [31:0] ifpc, input logic robv,
                       input logic [31:0] robpc, input int robghr, input logic tk,
                       input logic mp, input logic r);
    @(negedge clk);
    set_inputs(ifv, ifpc, robv, robpc, robghr, tk, mp, r);
    #1;
  endtask

  // Apply the architectural rules for the edge about to happen, then take it.
  task automatic tick();
    int p [2];
    int k;
    for (int u = 0; u < 2; u++) p[u] = model_pred(u);
    if (rdy) begin
      if (cur_robv) begin
        for (int u = 0; u < 2; u++) begin
          k = idx(u, cur_robpc, cur_robghr);
          if (cur_taken) pht[u][k] = (pht[u][k] < CMAX) ? pht[u][k] + 1 : CMAX;
          else           pht[u][k] = (pht[u][k] > 0)    ? pht[u][k] - 1 : 0;
        end
        commits = commits + 32'd1;
        if (cur_misp) misp = misp + 32'd1;
      end
      for (int u = 0; u < 2; u++) begin
        if (cur_robv && cur_misp) ghr[u] = (cur_robghr * 2 + int'(cur_taken)) % (1 << HB);
        else if (cur_ifv)         ghr[u] = (ghr[u] * 2 + p[u]) % (1 << HB);
      end
    end
    @(posedge clk);
  endtask

  task automatic step(input logic ifv, input logic [31:0] ifpc, input logic robv,
                      input logic [31:0] robpc, input int robghr, input logic tk,
                      input logic mp, input logic r);
    drive(ifv, ifpc, robv, robpc, robghr, tk, mp, r);
    check_all();
    tick();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    set_inputs(0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    check("rst.gs.pred_ghr",    32'(if_gs.pred_ghr),   32'h0);
    check("rst.gs.pred_taken",  32'(if_gs.pred_taken), 32'h0);
    check("rst.gs.commits",     if_gs.stat_commits,     32'h0);
    check("rst.gs.mispredicts", if_gs.stat_mispredicts, 32'h0);
    check("rst.bm.pred_ghr",    32'(if_bm.pred_ghr),   32'h0);
    check("rst.bm.commits",     if_bm.stat_commits,     32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    set_inputs(0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("por.gs.pred_ghr", 32'(if_gs.pred_ghr), 32'h0);
    check("por.gs.commits",  if_gs.stat_commits,  32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Every entry starts weakly not-taken.
    for (int i = 0; i < N; i++) step(0, 32'(i * 4), 0, 32'h0, 0, 0, 0, 1);

    // Saturation at the top and at zero.
    repeat (5) step(0, 32'h100, 1, 32'h100, 0, 1, 0, 1);
    drive(0, 32'h100, 1, 32'h100, 0, 0, 0, 1);
    check_all();
    check("sat.top", 32'(if_bm.pred_taken), 32'h1);
    tick();
    drive(0, 32'h100, 0, 32'h0, 0, 0, 0, 1);
    check("sat.hold_taken", 32'(if_bm.pred_taken), 32'h1);
    tick();
    repeat (4) step(0, 32'h100, 1, 32'h100, 0, 0, 0, 1);
    drive(0, 32'h100, 0, 32'h0, 0, 0, 0, 1);
    check_all();
    check("sat.bottom", 32'(if_bm.pred_taken), 32'h0);
    tick();

    async_reset();

    // Repair beats a same-cycle speculative shift.
    drive(1, 32'h0, 1, 32'h300, 42, 1, 1, 1);
    check_all();
    check("repair.pred", 32'(if_gs.pred_taken), 32'h0);
    tick();
    drive(0, 32'h0, 0, 32'h0, 0, 0, 0, 1);
    check_all();
    check("repair.gs.ghr", 32'(if_gs.pred_ghr), 32'h15);
    check("repair.bm.ghr", 32'(if_bm.pred_ghr), 32'h15);
    check("repair.misp",   if_gs.stat_mispredicts, 32'h1);
    tick();

    // Hash separation: pc 0x104 with GHR=1 lands on index 0, not index 1.
    step(0, 32'h0, 1, 32'h13C, 0, 1, 1, 1);
    step(0, 32'h104, 1, 32'h104, 1, 1, 0, 1);
    drive(0, 32'h104, 0, 32'h0, 0, 0, 0, 1);
    check_all();
    check("hash.ghr1.ghr",  32'(if_gs.pred_ghr),   32'h1);
    check("hash.ghr1.pred", 32'(if_gs.pred_taken), 32'h1);
    tick();
    step(0, 32'h0, 1, 32'h2C0, 0, 0, 1, 1);
    drive(0, 32'h104, 0, 32'h0, 0, 0, 0, 1);
    check_all();
    check("hash.ghr0.ghr",  32'(if_gs.pred_ghr),   32'h0);
    check("hash.ghr0.pred", 32'(if_gs.pred_taken), 32'h0);
    tick();

    // Stall: nothing moves while rdy is low.
    repeat (3) step(1, $urandom, 1, $urandom, int'($urandom_range(0, 63)), 1'($urandom), 1, 0);
    step(0, 32'h0, 0, 32'h0, 0, 0, 0, 1);

    // Read/write collision on one entry.
    drive(0, 32'h80, 1, 32'h80, 0, 1, 0, 1);
    check_all();
    check("coll.gs.old", 32'(if_gs.pred_taken), 32'h0);
    check("coll.bm.old", 32'(if_bm.pred_taken), 32'h0);
    tick();
    drive(0, 32'h80, 0, 32'h0, 0, 0, 0, 1);
    check_all();
    check("coll.gs.new", 32'(if_gs.pred_taken), 32'h1);
    check("coll.bm.new", 32'(if_bm.pred_taken), 32'h1);
    tick();

    // Random traffic over a small PC window to provoke aliasing and collisions.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ipc, rpc;
      ipc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2);
      rpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2);
      if (n == 200) async_reset();
      step(1'($urandom), ipc, 1'($urandom), rpc, int'($urandom_range(0, 63)),
           1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised direction predictor replacing the fixed 64-entry, 2-bit, PC-indexed table. Indexes a pattern history table (PHT) of saturating counters with PC XOR global history. The history is speculatively updated at fetch and repaired from the RoB on mispredict. Sits between InsFetch (prediction) and RoB (training/repair), and exposes commit/mispredict statistics.

## Interface
Parameters:
- INDEX_BITS, 6: PHT has 2^INDEX_BITS entries; index uses pc[INDEX_BITS+1:2].
- CTR_BITS, 2: counter width, 2..4.
- HIST_BITS, 6: global history register (GHR) width, 1..INDEX_BITS.
- USE_GHR, 1: 1 = gshare; 0 = bimodal (index = PC bits only; GHR still maintained).

Ports:
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; when 0, all state holds.
- if_valid  in  1  fetch is consuming a prediction this cycle.
- if_pc  in  32  fetch PC.
- pred_taken  out  1  predicted direction, combinational from PHT and GHR.
- pred_ghr  out  HIST_BITS  GHR value used for this prediction; travels with the instruction to the RoB.
- rob_valid  in  1  branch commit this cycle.
- rob_pc  in  32  committed branch PC.
- rob_ghr  in  HIST_BITS  pred_ghr recorded at fetch.
- rob_taken  in  1  actual direction.
- rob_mispredict  in  1  actual direction differed from prediction; qualified by rob_valid.
- stat_commits  out  32  committed-branch count.
- stat_mispredicts  out  32  mispredict count.

## Operation
- Index function: idx(pc,h) = pc[INDEX_BITS+1:2] XOR (USE_GHR ? zero-extend(h) : 0).
- Predict: pred_taken = MSB of PHT[idx(if_pc, GHR)]. pred_ghr = GHR.
- Speculative history: on if_valid && rdy_in, GHR <= {GHR[HIST_BITS-2:0], pred_taken}. For HIST_BITS=1, GHR <= pred_taken.
- Train: on rob_valid && rdy_in, PHT[idx(rob_pc, rob_ghr)] increments if rob_taken, otherwise decrements. Saturates at 2^CTR_BITS-1 and at 0.
- Repair: on rob_valid && rob_mispredict && rdy_in, GHR <= {rob_ghr[HIST_BITS-2:0], rob_taken}. Repair has priority over a same-cycle speculative shift.
- Statistics: stat_commits increments on every trained commit; stat_mispredicts increments on trained commits with rob_mispredict. Both wrap modulo 2^32.
- Reset: every PHT entry = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for 2 bits). GHR = 0, both stats = 0. Hence pred_taken = 0 and pred_ghr = 0 out of reset.

## Timing
- Prediction is zero latency (same cycle as if_pc).
- A PHT write lands at the clock edge and is visible to predictions from the next cycle. If a same-cycle read and write hit one entry, the read returns the old value.
- A GHR update is visible to the next cycle's prediction.
- Reset assertion mid-operation clears state immediately, regardless of clk_in or rdy_in. Deassertion takes effect at the next edge.
- rdy_in = 0: no PHT, GHR or stat change, even if if_valid or rob_valid is high. Outputs still track if_pc combinationally.
- rob_mispredict without rob_valid is ignored.

## Structure
- The shared constants header holds default widths and a `CTR_WEAK_NT` encoding helper.
- Sub-module `sat_counter_table` holds the PHT: parametrised depth/width, async read port, one sync write port with saturating inc/dec, async reset to the weak-not-taken value.
- The top level holds the GHR, index hashing, repair priority and stat counters.

## Test plan
- Reset: drive rst_n_in = 0 mid-run, then release. Required: pred_taken = 0, pred_ghr = 0, stats = 0, every PHT entry = 01.
- Saturation: with USE_GHR = 0, commit rob_pc = 0x100 taken 5 times. Required: counter reaches 11 and stops there, pred_taken = 1 for if_pc 0x100. Then 5 not-taken commits: counter reaches 00, pred_taken = 0.
- Hash separation: with GHR = 6'b000001, pc 0x104 maps to index 0. Train taken with rob_ghr = 1 and rob_pc = 0x104. Required: if_pc 0x104 with GHR = 0 (index 1) still predicts not-taken; with GHR = 1 it predicts taken after 1 commit.
- Repair priority: same cycle if_valid = 1 (pred 0) and mispredict with rob_ghr = 6'b101010, rob_taken = 1. Required: next GHR = 6'b010101; stat_mispredicts = 1.
- Stall: rdy_in = 0 with if_valid = 1 and rob_valid = 1 for 3 cycles. Required: GHR, PHT and stats unchanged.
- Read/write collision: predict and train the same index in one cycle. Required: pred_taken reflects the old counter; the next cycle reflects the new one.
